// File: rtl/tmr_fault_monitor.sv
// Triplicated-lane majority voter with per-lane fault attribution, lane retirement
// after persistent mismatches, degraded two-lane voting and a lane resync handshake.
module tmr_fault_monitor #(
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16,
    parameter int PERSIST_TH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] result_a_i,
    input  logic [DATA_W-1:0] result_b_i,
    input  logic [DATA_W-1:0] result_c_i,
    input  logic              clear_i,
    input  logic              resync_ack_i,
    output logic [DATA_W-1:0] voted_o,
    output logic              voted_valid_o,
    output logic [2:0]        fault_o,
    output logic              system_fault_o,
    output logic [2:0]        lane_dead_o,
    output logic [1:0]        mode_o,
    output logic [CNT_W-1:0]  fault_cnt_a_o,
    output logic [CNT_W-1:0]  fault_cnt_b_o,
    output logic [CNT_W-1:0]  fault_cnt_c_o,
    output logic              resync_req_o,
    output logic [2:0]        resync_lane_o
);

    localparam int CONS_W = 4;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        DEGRADED = 2'd1,
        FAILED   = 2'd2
    } mode_t;

    function automatic logic [DATA_W-1:0] majority(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic [DATA_W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    endfunction

    function automatic logic [2:0] lowest_one(input logic [2:0] v);
        if (v[0])      return 3'b001;
        else if (v[1]) return 3'b010;
        else if (v[2]) return 3'b100;
        else           return 3'b000;
    endfunction

    function automatic mode_t mode_of(input logic [2:0] d);
        logic [1:0] n;
        n = 2'(d[0]) + 2'(d[1]) + 2'(d[2]);
        if (n == 2'd0)      return NORMAL;
        else if (n == 2'd1) return DEGRADED;
        else                return FAILED;
    endfunction

    logic [DATA_W-1:0] voted_p1;
    logic              vld_p1;
    logic [2:0]        fault_p1;
    logic              sys_p1;
    logic [2:0]        dead_p1;
    logic              req_p1;
    logic [2:0]        lane_p1;
    mode_t             mode_p1;
    logic [CONS_W-1:0] cons_p1 [3];
    logic [CNT_W-1:0]  tot_p1  [3];

    logic [DATA_W-1:0] lane_val [3];
    logic [DATA_W-1:0] maj;
    logic [DATA_W-1:0] vote_val;
    logic [DATA_W-1:0] pair_x;
    logic [DATA_W-1:0] pair_y;
    logic [2:0]        flt;
    logic              sys;
    logic              hold_cons;
    logic [2:0]        revive;
    logic [2:0]        death;
    logic [2:0]        dead_n;
    logic [CONS_W-1:0] cons_n [3];

    assign lane_val[0] = result_a_i;
    assign lane_val[1] = result_b_i;
    assign lane_val[2] = result_c_i;
    assign maj         = majority(result_a_i, result_b_i, result_c_i);

    // With a lane retired, a disagreement between the two survivors cannot be blamed on either.
    always_comb begin
        vote_val  = voted_p1;
        flt       = 3'b000;
        sys       = 1'b0;
        hold_cons = 1'b0;
        pair_x    = result_a_i;
        pair_y    = result_b_i;
        if (valid_i) begin
            case (mode_p1)
                NORMAL: begin
                    vote_val = maj;
                    for (int i = 0; i < 3; i++) flt[i] = (lane_val[i] != maj);
                    sys = (result_a_i != result_b_i) && (result_a_i != result_c_i) &&
                          (result_b_i != result_c_i);
                end
                DEGRADED: begin
                    case (dead_p1)
                        3'b001:  begin pair_x = result_b_i; pair_y = result_c_i; end
                        3'b010:  begin pair_x = result_a_i; pair_y = result_c_i; end
                        default: begin pair_x = result_a_i; pair_y = result_b_i; end
                    endcase
                    if (pair_x == pair_y) begin
                        vote_val = pair_x;
                    end else begin
                        sys       = 1'b1;
                        hold_cons = 1'b1;
                    end
                end
                default: begin
                    sys       = 1'b1;
                    hold_cons = 1'b1;
                end
            endcase
        end
    end

    // A revived lane restarts clean; its own mismatch on the reviving edge is ignored.
    always_comb begin
        revive = (resync_ack_i && req_p1) ? lane_p1 : 3'b000;
        death  = 3'b000;
        for (int i = 0; i < 3; i++) begin
            cons_n[i] = cons_p1[i];
            if (revive[i]) begin
                cons_n[i] = '0;
            end else if (!dead_p1[i] && valid_i && !hold_cons) begin
                if (flt[i]) begin
                    if (cons_p1[i] == CONS_W'(PERSIST_TH - 1)) begin
                        death[i]  = 1'b1;
                        cons_n[i] = '0;
                    end else begin
                        cons_n[i] = cons_p1[i] + CONS_W'(1);
                    end
                end else begin
                    cons_n[i] = '0;
                end
            end
        end
        dead_n = (dead_p1 & ~revive) | death;
    end

    // Stage p1: voted sample, fault flags, lane state and counters all register here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            voted_p1 <= '0;
            vld_p1   <= 1'b0;
            fault_p1 <= 3'b000;
            sys_p1   <= 1'b0;
            dead_p1  <= 3'b000;
            req_p1   <= 1'b0;
            lane_p1  <= 3'b000;
            mode_p1  <= NORMAL;
            for (int i = 0; i < 3; i++) begin
                cons_p1[i] <= '0;
                tot_p1[i]  <= '0;
            end
        end else begin
            voted_p1 <= vote_val;
            vld_p1   <= valid_i;
            fault_p1 <= flt;
            sys_p1   <= sys;
            dead_p1  <= dead_n;
            req_p1   <= |dead_n;
            lane_p1  <= lowest_one(dead_n);
            mode_p1  <= mode_of(dead_n);
            for (int i = 0; i < 3; i++) begin
                cons_p1[i] <= cons_n[i];
                if (clear_i)     tot_p1[i] <= '0;
                else if (flt[i]) tot_p1[i] <= sat_inc(tot_p1[i]);
            end
        end
    end

    assign voted_o        = voted_p1;
    assign voted_valid_o  = vld_p1;
    assign fault_o        = fault_p1;
    assign system_fault_o = sys_p1;
    assign lane_dead_o    = dead_p1;
    assign mode_o         = mode_p1;
    assign fault_cnt_a_o  = tot_p1[0];
    assign fault_cnt_b_o  = tot_p1[1];
    assign fault_cnt_c_o  = tot_p1[2];
    assign resync_req_o   = req_p1;
    assign resync_lane_o  = lane_p1;

endmodule
